fp_mul_norm_round: RTL

FP_MUL_NORM_ROUND -- requirements
Module: fp_mul_norm_round

---
 rtl/fpu_pkg.sv | 26 ++
 rtl/fp_round_rne.sv | 28 ++
 rtl/fp_mul_norm_round.sv | 110 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants and types for the FP multiply normalize/round pipeline
//   BIAS, EXP_INF, QNAN  - IEEE-754 single-precision constants
//   FLAG_*               - bit indices into the 4-bit {invalid, overflow, underflow, inexact} flag vector
//   exp_t                - 10-bit signed exponent, wide enough that no intermediate wraps
//   s1_t                 - normalized operand held between the two pipeline stages
package fpu_pkg;
    localparam int BIAS = 127;
    localparam int EXP_INF = 255;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam int FLAG_INVALID = 3;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT = 0;
    typedef logic signed [9:0] exp_t;
    typedef struct packed {
        logic sign;
        exp_t exp;
        logic [22:0] mant;
        logic g;
        logic r;
        logic s;
        logic nan;
        logic inf;
        logic zero;
    } s1_t;
endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: combinational round-to-nearest-even with post-round renormalize
//   mant, g, r, s  - 23-bit fraction plus guard/round/sticky bits
//   exp            - exponent before rounding
//   frac, exp_out  - rounded fraction and exponent (carry out of the fraction bumps exp)
//   inexact        - any discarded bit was set
module fp_round_rne
    import fpu_pkg::*;
(
    input  logic [22:0] mant,
    input  logic        g,
    input  logic        r,
    input  logic        s,
    input  exp_t        exp,
    output logic [22:0] frac,
    output exp_t        exp_out,
    output logic        inexact
);
    logic        up;
    logic [23:0] sum;
    always_comb begin
        up = g && (r || s || mant[0]);
        sum = {1'b0, mant} + {23'd0, up};
        // on carry the low 23 bits of sum are already zero: 1.111..1 + ulp = 10.000..0
        frac = sum[22:0];
        exp_out = exp + exp_t'({9'd0, sum[23]});
        inexact = g || r || s;
    end
endmodule

// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round: 2-stage valid/ready pipeline that normalizes, rounds and packs a 24x24 mantissa product
//   clk, rst_n                    - clock, asynchronous active-low reset
//   in_valid/in_ready             - upstream handshake
//   in_sign, in_exp, in_prod      - sign, biased exponent sum (ea+eb-127), raw mantissa product
//   in_nan, in_inf, in_zero       - operand class flags
//   out_valid/out_ready           - downstream handshake
//   out_result, out_flags         - packed single-precision result, {invalid, overflow, underflow, inexact}
module fp_mul_norm_round
    import fpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic signed [9:0]  in_exp,
    input  logic [47:0]        in_prod,
    input  logic               in_nan,
    input  logic               in_inf,
    input  logic               in_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
    output logic [3:0]         out_flags
);
    logic        s1_valid, s2_valid, s1_load, s2_load;
    s1_t         s1, n;
    logic [22:0] r_frac;
    exp_t        r_exp;
    logic        r_inexact;
    logic [31:0] res;
    logic [3:0]  flg;

    assign s2_load = !s2_valid || out_ready;
    assign s1_load = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign out_valid = s2_valid;

    // a set bit 47 means the product is in [2,4): shift one more place and bump the exponent
    always_comb begin
        n.sign = in_sign;
        n.nan = in_nan;
        n.inf = in_inf;
        n.zero = in_zero;
        n.mant = in_prod[47] ? in_prod[46:24] : in_prod[45:23];
        n.g = in_prod[47] ? in_prod[23] : in_prod[22];
        n.r = in_prod[47] ? in_prod[22] : in_prod[21];
        n.s = in_prod[47] ? |in_prod[21:0] : |in_prod[20:0];
        n.exp = in_exp + exp_t'({9'd0, in_prod[47]});
    end

    fp_round_rne u_round (
        .mant    (s1.mant),
        .g       (s1.g),
        .r       (s1.r),
        .s       (s1.s),
        .exp     (s1.exp),
        .frac    (r_frac),
        .exp_out (r_exp),
        .inexact (r_inexact)
    );

    // class flags take priority over the numeric path; overflow/underflow use the post-round exponent
    always_comb begin
        res = {s1.sign, 31'd0};
        flg = '0;
        if (s1.nan) begin
            res = QNAN;
        end else if (s1.inf && s1.zero) begin
            res = QNAN;
            flg[FLAG_INVALID] = 1'b1;
        end else if (s1.inf) begin
            res = {s1.sign, 8'hFF, 23'd0};
        end else if (s1.zero) begin
            res = {s1.sign, 31'd0};
        end else if (r_exp >= exp_t'(EXP_INF)) begin
            res = {s1.sign, 8'hFF, 23'd0};
            flg[FLAG_OVERFLOW] = 1'b1;
            flg[FLAG_INEXACT] = 1'b1;
        end else if (r_exp <= exp_t'(0)) begin
            flg[FLAG_UNDERFLOW] = 1'b1;
            flg[FLAG_INEXACT] = 1'b1;
        end else begin
            res = {s1.sign, r_exp[7:0], r_frac};
            flg[FLAG_INEXACT] = r_inexact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1 <= '0;
            s2_valid <= 1'b0;
            out_result <= '0;
            out_flags <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) s1 <= n;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_result <= res;
                    out_flags <= flg;
                end
            end
        end
    end
endmodule
